tank_track_encoder: RTL
=======================

// Module: tank_track_encoder
// PURPOSE
//  Converts per-player 8-way digital joystick direction (up/down/left/right) into the two-lever
//  (left track W / right track X) forward/back signals used by tank-style arcade cores.
//  Sits between the keyboard/USB/DB9 input merge and the game core in the emu top level.
//  Parametrised successor of the fixed 2-player combinational table: adds debounce,
//  PWM half-speed diagonals, reverse-steer mode and a per-track reversal dead-time.
// PARAMETERS
//  NUM_PLAYERS  2   number of players (2 tracks each)
//  DEB_W        4   debounce counter width; DEB_TICKS must fit in DEB_W bits
//  DEB_TICKS    3   consecutive ce ticks a new direction must be stable before acceptance (0 = bypass)
//  PWM_W        4   width of the shared free-running PWM counter
//  PWM_DUTY     8   inner-track on-ticks per 2**PWM_W ticks in mode PWM
//  DEAD_TICKS   2   ce ticks a track is forced off on Fw<->Bk reversal (0 = none)
// PORTS
//  clk_sys    in   1          system clock; only clock in the block
//  Reset_n    in   1          asynchronous, active-low reset
//  ce         in   1          tick enable for debounce, PWM and dead-time counters
//  mode_i     in   2          0 LEGACY, 1 PWM, 2 REV_STEER, 3 = LEGACY
//  dir_i      in   4*NP       per player p: bits [4p+3:4p] = {up,down,left,right}, active-high, async
//  trk_fw_n_o out  2*NP       track forward, active-low; bit 2p = W (left), 2p+1 = X (right)
//  trk_bk_n_o out  2*NP       track back, active-low, same bit order
// BEHAVIOUR
//  Reset: all outputs 1 (inactive); all tracks OFF; debounce, PWM and dead counters 0; accepted dir = neutral.
//  Input path: 2-FF synchroniser on dir_i. Per-player debounce: candidate reloads on any change;
//    accepted <= candidate once it is unchanged for DEB_TICKS ce ticks. DEB_TICKS=0 accepts every clk.
//  Decode (registered, 1 clk): any illegal combo (up+down, left+right, >2 bits, 0 bits) = neutral.
//    LEGACY table {W,X}: U=F,F  UL=0,F  UR=F,0  R=F,B  DR=B,0  D=B,B  DL=0,B  L=B,F  neutral=0,0.
//    PWM: as LEGACY, but in UL/UR/DL/DR the stopped (inner) track drives the same direction
//      as the outer track while pwm_cnt < PWM_DUTY; otherwise it is off.
//    REV_STEER: as LEGACY, but DR and DL swap (DR=0,B  DL=B,0) so reversing steers like a car.
//  pwm_cnt: PWM_W bits, +1 per ce, wraps 2**PWM_W-1 -> 0; shared by all players.
//  Track FSM (per track, registered, 1 clk after decode): states OFF, FWD, BWD, DEAD.
//    OFF: req F -> FWD, req B -> BWD.  FWD: req 0 -> OFF, req B -> DEAD (DEAD_TICKS>0) else BWD.
//    BWD: symmetric.  DEAD: outputs off; counter loads DEAD_TICKS on entry, -1 per ce;
//      at 0 -> state given by current request (F/B/OFF). Req 0 during DEAD -> OFF immediately.
//    Output: FWD -> fw_n=0,bk_n=1; BWD -> fw_n=1,bk_n=0; OFF/DEAD -> both 1. Never both 0.
//  Latency: accepted change -> outputs 2 clk (decode + FSM); raw pin -> output 2+DEB_TICKS ce + 4 clk max.
//  mode_i change takes effect at next decode; a resulting reversal still passes DEAD.
//  Reset asserted mid-operation (incl. DEAD) forces outputs 1 asynchronously; no pending state survives.
//  Simultaneous ce and reversal request: DEAD entered, counter loads, first decrement on next ce.
// STRUCTURE
//  tank_ctrl_pkg: mode_e (MODE_LEGACY, MODE_PWM, MODE_REV_STEER), trk_req_e (REQ_OFF/REQ_FW/REQ_BK),
//    trk_state_e (OFF, FWD, BWD, DEAD), dir bit index constants.
//  Sub-module tank_track_fsm (one track: FSM + dead counter), instantiated 2*NUM_PLAYERS times;
//    sync, debounce, decode and pwm_cnt stay in the top module, generate-looped per player.
// TESTING
//  1 Reset: Reset_n=0 with dir_i=all ones -> fw_n=bk_n='1 throughout; release, dir=0 -> stays '1.
//  2 LEGACY, ce=1, P1 up: fw_n[1:0]=00, bk_n[1:0]=11 exactly DEB_TICKS+4 clk after pin; P1 right -> fw_n[0]=0, bk_n[1]=0.
//  3 Glitch/illegal: 1-clk up pulse (DEB_TICKS=3) -> no output change; up+down held -> all 1s.
//  4 Reversal, DEAD_TICKS=2: up -> down -> both tracks 11 for 2 ce ticks, then bk_n=00; down->0 in DEAD -> OFF next clk.
//  5 PWM, PWM_W=4, DUTY=8, up-left: X fw_n=0 constant; W fw_n=0 for 8 of every 16 ce ticks, bk_n[0]=1 always.
//  6 REV_STEER down-right -> bk_n[1]=0, W off; P2 (bits 7:4) independent of P1; Reset_n pulse in DEAD -> all 1s.

Source files
------------

// File: rtl/tank_track_encoder_pkg.sv
// tank_ctrl_pkg: shared types for the tank track encoder.
//   mode_e       operating mode (value 3 falls back to legacy behaviour)
//   trk_req_e    per-track request produced by the decoder
//   trk_state_e  per-track FSM state
//   trk_pair_t   {W (left), X (right)} request pair for one player
//   decode_dir   joystick nibble + mode + PWM phase -> request pair
package tank_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_LEGACY    = 2'd0,
        MODE_PWM       = 2'd1,
        MODE_REV_STEER = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_FW  = 2'd1,
        REQ_BK  = 2'd2
    } trk_req_e;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        DEAD = 2'd3
    } trk_state_e;

    // Bit positions inside one player's direction nibble.
    localparam int DIR_UP = 3;
    localparam int DIR_DN = 2;
    localparam int DIR_LT = 1;
    localparam int DIR_RT = 0;

    typedef struct packed {
        trk_req_e w;
        trk_req_e x;
    } trk_pair_t;

    // Every pattern not listed (opposing pairs, three or four bits, none)
    // falls through to neutral.
    function automatic trk_pair_t decode_dir(input logic [3:0] dir,
                                             input logic [1:0] mode,
                                             input logic       pwm_on);
        trk_pair_t r;
        logic      pwm;
        logic      rev;
        trk_req_e  inner_fw;
        trk_req_e  inner_bk;
        pwm      = (mode == MODE_PWM);
        rev      = (mode == MODE_REV_STEER);
        // Inner track of a diagonal follows the outer track only during the PWM on-phase.
        inner_fw = (pwm && pwm_on) ? REQ_FW : REQ_OFF;
        inner_bk = (pwm && pwm_on) ? REQ_BK : REQ_OFF;
        r.w = REQ_OFF;
        r.x = REQ_OFF;
        case (dir)                   // {up, down, left, right}
            4'b1000: begin r.w = REQ_FW;   r.x = REQ_FW;   end
            4'b1010: begin r.w = inner_fw; r.x = REQ_FW;   end
            4'b1001: begin r.w = REQ_FW;   r.x = inner_fw; end
            4'b0001: begin r.w = REQ_FW;   r.x = REQ_BK;   end
            4'b0101: begin
                // Reverse-steer swaps the rear diagonals so backing up steers like a car.
                if (rev) begin r.w = REQ_OFF; r.x = REQ_BK;   end
                else     begin r.w = REQ_BK;  r.x = inner_bk; end
            end
            4'b0100: begin r.w = REQ_BK;   r.x = REQ_BK;   end
            4'b0110: begin
                if (rev) begin r.w = REQ_BK;   r.x = REQ_OFF; end
                else     begin r.w = inner_bk; r.x = REQ_BK;  end
            end
            4'b0010: begin r.w = REQ_BK;   r.x = REQ_FW;   end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tank_track_encoder_if.sv
// tank_track_encoder_if: control/joystick bus of the tank track encoder.
//   ce          tick enable for debounce, PWM and dead-time counters
//   mode_i      operating mode (tank_ctrl_pkg::mode_e encoding)
//   dir_i       per player p: [4p+3:4p] = {up,down,left,right}, active-high, async
//   trk_fw_n_o  track forward, active-low; bit 2p = W (left), 2p+1 = X (right)
//   trk_bk_n_o  track back, active-low, same bit order
// master = input merge side, slave = encoder.
interface tank_track_encoder_if #(
    parameter int NUM_PLAYERS = 2
);
    logic                     ce;
    logic [1:0]               mode_i;
    logic [4*NUM_PLAYERS-1:0] dir_i;
    logic [2*NUM_PLAYERS-1:0] trk_fw_n_o;
    logic [2*NUM_PLAYERS-1:0] trk_bk_n_o;

    modport master (output ce, mode_i, dir_i, input  trk_fw_n_o, trk_bk_n_o);
    modport slave  (input  ce, mode_i, dir_i, output trk_fw_n_o, trk_bk_n_o);
endinterface

// File: rtl/tank_track_encoder_track_fsm.sv
// tank_track_fsm: one track lever (OFF/FWD/BWD/DEAD) with reversal dead-time.
//   clk_sys, Reset_n  clock, async active-low reset
//   ce                tick enable for the dead-time counter
//   req               decoded request for this track
//   fw_n, bk_n        active-low lever outputs; never both low
module tank_track_fsm
    import tank_ctrl_pkg::*;
#(
    parameter int DEAD_TICKS = 2
) (
    input  logic     clk_sys,
    input  logic     Reset_n,
    input  logic     ce,
    input  trk_req_e req,
    output logic     fw_n,
    output logic     bk_n
);
    localparam int            CW        = (DEAD_TICKS < 2) ? 1 : $clog2(DEAD_TICKS + 1);
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_TICKS);

    trk_state_e    state, state_nxt;
    logic [CW-1:0] dead_cnt, dead_cnt_nxt;

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= OFF;
            dead_cnt <= '0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        dead_cnt_nxt = dead_cnt;
        case (state)
            OFF: begin
                if (req == REQ_FW)      state_nxt = FWD;
                else if (req == REQ_BK) state_nxt = BWD;
            end
            FWD: begin
                if (req == REQ_OFF) state_nxt = OFF;
                else if (req == REQ_BK) begin
                    if (DEAD_TICKS > 0) begin
                        state_nxt    = DEAD;
                        dead_cnt_nxt = DEAD_LOAD;
                    end else begin
                        state_nxt = BWD;
                    end
                end
            end
            BWD: begin
                if (req == REQ_OFF) state_nxt = OFF;
                else if (req == REQ_FW) begin
                    if (DEAD_TICKS > 0) begin
                        state_nxt    = DEAD;
                        dead_cnt_nxt = DEAD_LOAD;
                    end else begin
                        state_nxt = FWD;
                    end
                end
            end
            DEAD: begin
                // Releasing the lever cancels the dead-time at once. Otherwise the
                // tick that would bring the counter to zero is the exit tick, so the
                // track stays dark for exactly DEAD_TICKS ce ticks.
                if (req == REQ_OFF) state_nxt = OFF;
                else if (ce) begin
                    if (dead_cnt <= CW'(1)) state_nxt = (req == REQ_FW) ? FWD : BWD;
                    else                    dead_cnt_nxt = dead_cnt - 1'b1;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    assign fw_n = (state != FWD);
    assign bk_n = (state != BWD);

endmodule

// File: rtl/tank_track_encoder.sv
// tank_track_encoder: joystick directions -> two-lever tank track controls.
//   clk_sys   system clock
//   Reset_n   async active-low reset; forces all outputs inactive (1)
//   bus       tank_track_encoder_if.slave: ce, mode_i, dir_i in; trk_fw_n_o, trk_bk_n_o out
// Path: 2-FF sync -> per-player debounce -> registered decode -> per-track FSM.
module tank_track_encoder
    import tank_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DEB_W       = 4,
    parameter int DEB_TICKS   = 3,
    parameter int PWM_W       = 4,
    parameter int PWM_DUTY    = 8,
    parameter int DEAD_TICKS  = 2
) (
    input logic                  clk_sys,
    input logic                  Reset_n,
    tank_track_encoder_if.slave  bus
);
    localparam int               DIR_W = 4 * NUM_PLAYERS;
    localparam logic [PWM_W:0]   DUTY  = (PWM_W + 1)'(PWM_DUTY);

    logic [DIR_W-1:0]         dir_s1, dir_s2;
    logic [PWM_W-1:0]         pwm_cnt;
    logic                     pwm_on;
    logic [2*NUM_PLAYERS-1:0] fw_n, bk_n;

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_s1 <= '0;
            dir_s2 <= '0;
        end else begin
            dir_s1 <= bus.dir_i;
            dir_s2 <= dir_s1;
        end
    end

    // Shared by all players so every inner track pulses in phase.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n)    pwm_cnt <= '0;
        else if (bus.ce) pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign pwm_on = ({1'b0, pwm_cnt} < DUTY);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_plr
        logic [3:0] acc;
        trk_pair_t  dec_q;

        if (DEB_TICKS == 0) begin : g_nodeb
            always_ff @(posedge clk_sys or negedge Reset_n) begin
                if (!Reset_n) acc <= '0;
                else          acc <= dir_s2[4*p +: 4];
            end
        end else begin : g_deb
            localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);
            logic [3:0]       cand;
            logic [DEB_W-1:0] cnt;

            // The reload edge itself counts as the first stable tick when ce is high.
            always_ff @(posedge clk_sys or negedge Reset_n) begin
                if (!Reset_n) begin
                    cand <= '0;
                    cnt  <= '0;
                    acc  <= '0;
                end else if (dir_s2[4*p +: 4] != cand) begin
                    cand <= dir_s2[4*p +: 4];
                    cnt  <= bus.ce ? DEB_W'(1) : '0;
                end else if (bus.ce && cand != acc) begin
                    if (cnt >= DEB_LAST) acc <= cand;
                    else                 cnt <= cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_sys or negedge Reset_n) begin
            if (!Reset_n) dec_q <= '{w: REQ_OFF, x: REQ_OFF};
            else          dec_q <= decode_dir(acc, bus.mode_i, pwm_on);
        end

        tank_track_fsm #(.DEAD_TICKS(DEAD_TICKS)) u_trk_w (
            .clk_sys (clk_sys),
            .Reset_n (Reset_n),
            .ce      (bus.ce),
            .req     (dec_q.w),
            .fw_n    (fw_n[2*p]),
            .bk_n    (bk_n[2*p])
        );

        tank_track_fsm #(.DEAD_TICKS(DEAD_TICKS)) u_trk_x (
            .clk_sys (clk_sys),
            .Reset_n (Reset_n),
            .ce      (bus.ce),
            .req     (dec_q.x),
            .fw_n    (fw_n[2*p+1]),
            .bk_n    (bk_n[2*p+1])
        );
    end

    assign bus.trk_fw_n_o = fw_n;
    assign bus.trk_bk_n_o = bk_n;

endmodule
